dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (32 words: async read, write on posedge clk) between
//  the pipeline MEM stage and a secondary debug/DMA port.
//  CPU has priority. A wait counter bounds debug starvation.
//  When debug steals a cycle, the arbiter stalls the pipeline. Sits between MEM stage and data memory.
// PARAMETERS
//  STARVE_LIMIT  8   cycles a pending debug request may lose to CPU before forced grant (0..255)
// PORTS
//  clk         in   1   system clock, all state updates on rising edge
//  clrn        in   1   asynchronous active-low reset
//  cpu_req     in   1   MEM stage performs load or store this cycle
//  cpu_we      in   1   MEM stage store
//  cpu_addr    in   32  byte address from MEM stage
//  cpu_wdata   in   32  store data
//  cpu_rdata   out  32  load data; combinational copy of mem_dataout
//  cpu_stall   out  1   MEM stage lost arbitration; pipeline must freeze and re-present request
//  dbg_req     in   1   debug request; held high with we/addr/wdata stable until dbg_ack
//  dbg_we      in   1   debug write
//  dbg_addr    in   32  debug byte address
//  dbg_wdata   in   32  debug write data
//  dbg_ack     out  1   one-cycle completion pulse
//  dbg_rdata   out  32  registered read data, valid while dbg_ack=1, held until next debug grant
//  mem_we      out  1   to memory we
//  mem_addr    out  32  to memory addr (full byte address; memory decodes [6:2])
//  mem_datain  out  32  to memory datain
//  mem_dataout in   32  from memory dataout
// BEHAVIOUR
//  States: IDLE (no debug pending), WAIT (debug pending, losing to CPU), ACK (debug done).
//  Encoding: IDLE=2'd0, WAIT=2'd1, ACK=2'd2; 2'd3 is illegal and recovers to IDLE.
//  dbg_grant (combinational) = clrn & dbg_req & state!=ACK & (!cpu_req | wait_cnt>=STARVE_LIMIT).
//  Memory mux:
//   - dbg_grant=1: mem_* driven from dbg_*.
//   - otherwise: mem_* driven from cpu_*, with mem_we = cpu_req & cpu_we & clrn.
//  cpu_stall = dbg_grant & cpu_req. A stalled CPU store must not write memory.
//  On dbg_grant, at the clock edge:
//   - dbg_rdata <= mem_dataout (also captured on writes);
//   - wait_cnt <= 0;
//   - state -> ACK.
//  ACK lasts exactly one cycle:
//   - dbg_ack=1; no debug grant; CPU owns memory unconditionally;
//   - next state is IDLE. This guarantees CPU progress after every steal.
//  Transitions:
//   - IDLE -> WAIT when dbg_req & cpu_req & no grant.
//   - WAIT -> IDLE if dbg_req drops (request withdrawn; wait_cnt cleared).
//  wait_cnt (8 bit):
//   - increments in each cycle where dbg_req=1, no grant and state!=ACK;
//   - saturates at 255;
//   - is cleared on grant or withdrawal.
//  STARVE_LIMIT=0: debug wins every eligible cycle, never back-to-back (ACK gap). Worst-case debug latency:
//   STARVE_LIMIT+1 cycles to grant, +1 to ack.
//  Requester keeps dbg_req high during the ACK cycle: the request is ignored. dbg_req high in the cycle after ACK is a new request.
//  Write then read, same address, across ports: the order is grant order. A CPU read in the ACK cycle sees the debug write.
//  Reset (async, any time, including mid-WAIT or ACK):
//   - state=IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0;
//   - mem_we=0 and cpu_stall=0 while clrn=0;
//   - after release, a still-held dbg_req is re-arbitrated from wait_cnt=0.
//  No address checking: misaligned or out-of-range addresses pass through; the memory aliases on [6:2].
// STRUCTURE
//  Shared header dmem_arb_defs.vh: state encodings, STARVE_W=8.
//  One sub-module arb_wait_counter: saturating counter with inc/clr inputs and a ge_limit output.
//  The rest is flat: FSM, mux, rdata register.
// TESTING
//  1 CPU only: cpu_req=1, we=1, addr=0x0C, wdata=0xDEADBEEF; then read 0x0C
//    -> cpu_rdata=0xDEADBEEF, cpu_stall never 1.
//  2 Debug idle bus: dbg_req=1, we=0, addr=0x10 (preloaded 0x12345678), cpu_req=0
//    -> grant in cycle 0, dbg_ack in cycle 1, dbg_rdata=0x12345678.
//  3 Starvation: cpu_req=1 continuously, dbg write 0x55AA to 0x04, STARVE_LIMIT=8
//    -> cpu_stall exactly in cycle 8 (one cycle), ack in cycle 9, CPU un-stalled in 9.
//  4 Stalled store: CPU store 0x1111 to 0x08 in the stolen cycle
//    -> memory unchanged that cycle; CPU re-presents in the ACK cycle; final mem[2]=0x1111.
//  5 Reset mid-WAIT: clrn low at wait_cnt=5, dbg_req held
//    -> dbg_ack=0, dbg_rdata=0 immediately; after release, grant after 8 more CPU cycles.
//  6 Held dbg_req after ack with cpu_req=0
//    -> second grant 2 cycles after first; ack pulses separated by exactly one idle cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the width of the debug starvation counter.
package dmem_arbiter_pkg;

    localparam int unsigned STARVE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_ACK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating count of cycles a pending debug request has lost to the CPU;
// flags when the count has reached the starvation limit.
module dmem_arbiter_wait_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic clrn,
    input  logic inc,
    input  logic clr,
    output logic ge_limit
);

    logic [STARVE_W-1:0] cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

    assign ge_limit = (32'(cnt) >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (priority) and a
// debug/DMA port, with bounded debug starvation and a one-cycle ACK gap.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    arb_state_e state;
    logic       ge_limit;
    logic       grant_core;
    logic       dbg_grant;
    logic       cnt_inc;
    logic       cnt_clr;

    // Registers use the grant without the reset term: they are held in reset
    // whenever clrn is low, so the result is identical.
    assign grant_core = dbg_req && (state != ARB_ACK) && (!cpu_req || ge_limit);
    assign dbg_grant  = clrn && grant_core;

    assign cnt_inc = dbg_req && !grant_core && (state != ARB_ACK);
    assign cnt_clr = grant_core || !dbg_req;

    dmem_arbiter_wait_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_wait_counter (
        .clk      (clk),
        .clrn     (clrn),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .ge_limit (ge_limit)
    );

    assign cpu_stall = dbg_grant && cpu_req;
    assign cpu_rdata = mem_dataout;

    always_comb begin
        mem_we     = clrn && cpu_req && cpu_we;
        mem_addr   = cpu_addr;
        mem_datain = cpu_wdata;
        if (dbg_grant) begin
            mem_we     = dbg_we;
            mem_addr   = dbg_addr;
            mem_datain = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ARB_IDLE;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= grant_core;
            if (grant_core) begin
                dbg_rdata <= mem_dataout;
            end
            case (state)
                ARB_IDLE: begin
                    if (grant_core) begin
                        state <= ARB_ACK;
                    end else if (dbg_req && cpu_req) begin
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (grant_core) begin
                        state <= ARB_ACK;
                    end else if (!dbg_req) begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_ACK: state <= ARB_IDLE;
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 32-word data memory
// (async read, write on rising clock edge).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_we;
    logic [31:0] mem_addr, mem_datain, mem_dataout;

    logic [31:0] mem [32] = '{default: 32'h0};

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[6:2]] <= mem_datain;
    end
    assign mem_dataout = mem[mem_addr[6:2]];

    dmem_arbiter #(
        .STARVE_LIMIT (8)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check(e.tag, got, e.val);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clrn = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0C; cpu_wdata = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10; dbg_wdata = 32'h0;
        #3;
        push("rst_ack", 32'd0);       pop_chk(32'(dbg_ack));
        push("rst_rdata", 32'd0);     pop_chk(dbg_rdata);
        push("rst_stall", 32'd0);     pop_chk(32'(cpu_stall));
        push("rst_mem_we", 32'd0);    pop_chk(32'(mem_we));
        @(negedge clk);
        clrn = 1'b1;
        dbg_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;

        // preload mem[4] and exercise the CPU-only path
        drive(1, 1, 32'h10, 32'h12345678, 0, 0, 0, 0);
        push("t1_pre_we", 32'd1);     pop_chk(32'(mem_we));
        drive(1, 1, 32'h0C, 32'hDEADBEEF, 0, 0, 0, 0);
        push("t1_wr_stall", 32'd0);   pop_chk(32'(cpu_stall));
        push("t1_wr_we", 32'd1);      pop_chk(32'(mem_we));
        drive(1, 0, 32'h0C, 32'h0, 0, 0, 0, 0);
        push("t1_rd_data", 32'hDEADBEEF); pop_chk(cpu_rdata);
        push("t1_rd_stall", 32'd0);   pop_chk(32'(cpu_stall));

        // debug read on an idle bus
        drive(0, 0, 32'h0C, 0, 1, 0, 32'h10, 0);
        push("t2_gnt_addr", 32'h10);  pop_chk(mem_addr);
        push("t2_stall", 32'd0);      pop_chk(32'(cpu_stall));
        push("t2_ack0", 32'd0);       pop_chk(32'(dbg_ack));
        drive(0, 0, 32'h0C, 0, 0, 0, 32'h10, 0);
        push("t2_ack1", 32'd1);       pop_chk(32'(dbg_ack));
        push("t2_rdata", 32'h12345678); pop_chk(dbg_rdata);
        drive(0, 0, 32'h0C, 0, 0, 0, 0, 0);
        push("t2_ack2", 32'd0);       pop_chk(32'(dbg_ack));
        push("t2_rdata_hold", 32'h12345678); pop_chk(dbg_rdata);

        // starvation: debug write wins only after 8 lost cycles
        for (int k = 0; k <= 10; k++) begin
            drive(1, 0, (k >= 9) ? 32'h04 : 32'h0C, 0, (k <= 9), 1, 32'h04, 32'h55AA);
            push($sformatf("t3_stall_c%0d", k), 32'(k == 8)); pop_chk(32'(cpu_stall));
            push($sformatf("t3_ack_c%0d", k), 32'(k == 9));   pop_chk(32'(dbg_ack));
            if (k == 8) begin
                push("t3_dbg_we", 32'd1);       pop_chk(32'(mem_we));
                push("t3_dbg_data", 32'h55AA);  pop_chk(mem_datain);
            end
            if (k == 9) begin
                push("t3_cpu_sees_dbg_wr", 32'h55AA); pop_chk(cpu_rdata);
            end
        end

        // stalled CPU store must not reach memory; it retries in the ACK cycle
        for (int k = 0; k <= 10; k++) begin
            if (k < 8)       drive(1, 0, 32'h0C, 0,        1, 1, 32'h0C, 32'h2222);
            else if (k <= 9) drive(1, 1, 32'h08, 32'h1111, (k <= 9), 1, 32'h0C, 32'h2222);
            else             drive(0, 0, 32'h0C, 0,        0, 0, 32'h0C, 0);
            push($sformatf("t4_stall_c%0d", k), 32'(k == 8)); pop_chk(32'(cpu_stall));
            if (k == 8) begin
                push("t4_steal_addr", 32'h0C); pop_chk(mem_addr);
            end
            if (k == 9) begin
                push("t4_mem2_untouched", 32'h0);   pop_chk(mem[2]);
                push("t4_retry_addr", 32'h08);      pop_chk(mem_addr);
                push("t4_retry_we", 32'd1);         pop_chk(32'(mem_we));
                push("t4_ack", 32'd1);              pop_chk(32'(dbg_ack));
                push("t4_rdata_old", 32'hDEADBEEF); pop_chk(dbg_rdata);
            end
            if (k == 10) begin
                push("t4_mem2_final", 32'h1111);    pop_chk(mem[2]);
                push("t4_mem3_final", 32'h2222);    pop_chk(mem[3]);
            end
        end

        // reset in the middle of WAIT with the request still held
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 32'h0C, 0, 1, 0, 32'h10, 0);
            push($sformatf("t5_pre_stall_c%0d", k), 32'd0); pop_chk(32'(cpu_stall));
        end
        @(negedge clk);
        clrn = 1'b0; cpu_we = 1'b1;
        #1;
        push("t5_rst_ack", 32'd0);    pop_chk(32'(dbg_ack));
        push("t5_rst_rdata", 32'd0);  pop_chk(dbg_rdata);
        push("t5_rst_stall", 32'd0);  pop_chk(32'(cpu_stall));
        push("t5_rst_we", 32'd0);     pop_chk(32'(mem_we));
        @(negedge clk);
        clrn = 1'b1; cpu_we = 1'b0;
        #1;
        push("t5_stall_r0", 32'd0);   pop_chk(32'(cpu_stall));
        push("t5_mem3_kept", 32'h2222); pop_chk(mem[3]);
        for (int r = 1; r <= 10; r++) begin
            drive(1, 0, 32'h0C, 0, (r <= 9), 0, 32'h10, 0);
            push($sformatf("t5_stall_r%0d", r), 32'(r == 8)); pop_chk(32'(cpu_stall));
            push($sformatf("t5_ack_r%0d", r), 32'(r == 9));   pop_chk(32'(dbg_ack));
            if (r == 9) begin
                push("t5_rdata", 32'h12345678); pop_chk(dbg_rdata);
            end
        end

        // held request after ACK is a fresh request, one idle cycle later
        for (int c = 0; c <= 4; c++) begin
            drive(0, 0, 32'h0C, 0, (c <= 3), 0, 32'h10, 0);
            push($sformatf("t6_addr_c%0d", c), (c == 0 || c == 2) ? 32'h10 : 32'h0C); pop_chk(mem_addr);
            push($sformatf("t6_ack_c%0d", c), 32'(c == 1 || c == 3));                 pop_chk(32'(dbg_ack));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
